// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard: tracks rd of the last DEPTH issued instructions
// and drives rs1/rs2 forwarding selects plus a load-use stall. Stats counters under FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard #(
  parameter  int DEPTH      = 2,
  parameter  int LOAD_STALL = 1,
  localparam int SELW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     dec_inst,
  input  logic            issue_valid,
  input  logic            flush,
  output logic [SELW-1:0] fwd_sel1,
  output logic [SELW-1:0] fwd_sel2,
  output logic            load_use_stall,
  output logic [31:0]     fwd_count,
  output logic [31:0]     stall_count
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ARI_R  = 7'b0110011;

  logic [DEPTH:1]      valid_q, valid_d;
  logic [DEPTH:1][4:0] rd_q, rd_d;
  logic [DEPTH:1]      ld_q, ld_d;

  logic [6:0]      opcode;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic            has_rd, has_rs1, has_rs2, dec_is_load;
  logic [SELW-1:0] sel1, sel2;
  logic            stall;
  logic            unused_funct;

  assign opcode       = dec_inst[6:0];
  assign dec_rd       = dec_inst[11:7];
  assign dec_rs1      = dec_inst[19:15];
  assign dec_rs2      = dec_inst[24:20];
  assign unused_funct = ^{dec_inst[31:25], dec_inst[14:12]};

  assign has_rd      = (opcode != OPC_BRANCH) && (opcode != OPC_STORE) && (dec_rd != 5'd0);
  assign has_rs1     = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
  assign has_rs2     = (opcode == OPC_ARI_R) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  assign dec_is_load = (opcode == OPC_LOAD);

  // Scan oldest to youngest so the youngest match overwrites; any young load hit stalls.
  always_comb begin
    sel1  = '0;
    sel2  = '0;
    stall = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid_q[k] && has_rs1 && (dec_rs1 != 5'd0) && (rd_q[k] == dec_rs1)) begin
        sel1 = SELW'(k);
        if ((k <= LOAD_STALL) && ld_q[k]) stall = 1'b1;
      end
      if (valid_q[k] && has_rs2 && (dec_rs2 != 5'd0) && (rd_q[k] == dec_rs2)) begin
        sel2 = SELW'(k);
        if ((k <= LOAD_STALL) && ld_q[k]) stall = 1'b1;
      end
    end
  end

  assign fwd_sel1       = sel1;
  assign fwd_sel2       = sel2;
  assign load_use_stall = stall;

  // Entries without a destination keep rd = 0 so they can never match a nonzero rs.
  always_comb begin
    valid_d = '0;
    rd_d    = rd_q;
    ld_d    = ld_q;
    for (int k = 2; k <= DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k]    = rd_q[k-1];
      ld_d[k]    = ld_q[k-1];
    end
    valid_d[1] = issue_valid && !stall;
    rd_d[1]    = has_rd ? dec_rd : 5'd0;
    ld_d[1]    = dec_is_load;
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rd_q    <= '0;
      ld_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      ld_q    <= ld_d;
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (((sel1 != '0) || (sel2 != '0)) && issue_valid && !stall) fwd_cnt_d = fwd_cnt_q + 32'd1;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_count   = fwd_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fwd_count   = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: directed scenarios plus random traffic,
// checked against a history-queue reference model.
module tb_fwd_scoreboard;
  localparam int DEPTH      = 2;
  localparam int LOAD_STALL = 1;
  localparam int SELW       = $clog2(DEPTH + 1);
`ifdef FWD_SCOREBOARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, ARI = 7'b0010011, R = 7'b0110011;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     dec_inst = 32'h13;
  logic            issue_valid = 1'b0;
  logic            flush = 1'b0;
  logic [SELW-1:0] fwd_sel1, fwd_sel2;
  logic            load_use_stall;
  logic [31:0]     fwd_count, stall_count;

  always #5 clk = ~clk;

  fwd_scoreboard #(.DEPTH(DEPTH), .LOAD_STALL(LOAD_STALL)) dut (
    .clk(clk), .rst(rst), .dec_inst(dec_inst), .issue_valid(issue_valid), .flush(flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .load_use_stall(load_use_stall),
    .fwd_count(fwd_count), .stall_count(stall_count)
  );

  typedef struct { int s1; int s2; bit st; logic [31:0] fc; logic [31:0] sc; } exp_t;
  typedef struct { bit v; logic [4:0] rd; bit ld; } ent_t;

  exp_t        expq[$];
  ent_t        hist[$];   // hist[0] is the youngest in-flight instruction
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_fc = 32'd0;
  logic [31:0] m_sc = 32'd0;
  bit          drv_done = 1'b0;

  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, op};
  endfunction

  // Which older instruction (1 = youngest) produces register rs, or 0 for the regfile.
  function automatic int producer(input logic [4:0] rs, input bit used);
    if (!used || rs == 5'd0) return 0;
    foreach (hist[i]) if (hist[i].v && hist[i].rd == rs) return i + 1;
    return 0;
  endfunction

  function automatic bit load_hit(input logic [4:0] rs, input bit used);
    if (!used || rs == 5'd0) return 1'b0;
    foreach (hist[i]) if ((i + 1) <= LOAD_STALL && hist[i].v && hist[i].ld && hist[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic [31:0] inst, input bit iv, input bit fl, input bit r);
    exp_t e;
    ent_t n;
    logic [6:0] op;
    bit writes, reads1, reads2;
    @(posedge clk);
    #1;
    rst = r; dec_inst = inst; issue_valid = iv; flush = fl;
    op     = inst[6:0];
    writes = !(op == BR || op == ST) && inst[11:7] != 5'd0;
    reads1 = !(op == LUI || op == AUIPC || op == JAL);
    reads2 = (op == R || op == ST || op == BR);
    if (r) begin
      hist.delete();
      m_fc = 32'd0; m_sc = 32'd0;
      e.s1 = 0; e.s2 = 0; e.st = 1'b0;
    end else begin
      e.s1 = producer(inst[19:15], reads1);
      e.s2 = producer(inst[24:20], reads2);
      e.st = load_hit(inst[19:15], reads1) || load_hit(inst[24:20], reads2);
    end
    e.fc = STATS ? m_fc : 32'd0;
    e.sc = STATS ? m_sc : 32'd0;
    expq.push_back(e);
    if (!r) begin
      if (e.st) m_sc = m_sc + 32'd1;
      if ((e.s1 != 0 || e.s2 != 0) && iv && !e.st) m_fc = m_fc + 32'd1;
      if (fl) foreach (hist[i]) hist[i].v = 1'b0;
      n.v  = iv && !e.st && !fl;
      n.rd = writes ? inst[11:7] : 5'd0;
      n.ld = (op == LD);
      hist.push_front(n);
      while (hist.size() > DEPTH) void'(hist.pop_back());
    end
  endtask

  task automatic expect_now(input string name, input int s1, input int s2, input bit st);
    #1;
    total++;
    if (int'(fwd_sel1) != s1 || int'(fwd_sel2) != s2 || load_use_stall != st) begin
      bad++;
      $display("FAIL %s: got sel1=%0d sel2=%0d stall=%0b, want sel1=%0d sel2=%0d stall=%0b",
               name, fwd_sel1, fwd_sel2, load_use_stall, s1, s2, st);
    end
  endtask

  task automatic expect_cnt(input string name, input logic [31:0] fc, input logic [31:0] sc);
    logic [31:0] wf, ws;
    #1;
    wf = STATS ? fc : 32'd0;
    ws = STATS ? sc : 32'd0;
    total++;
    if (fwd_count != wf || stall_count != ws) begin
      bad++;
      $display("FAIL %s: got fwd_count=%0d stall_count=%0d, want %0d %0d", name, fwd_count, stall_count, wf, ws);
    end
  endtask

  // Monitor: the outputs are valid every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        total++;
        if (int'(fwd_sel1) != e.s1 || int'(fwd_sel2) != e.s2 || load_use_stall != e.st ||
            fwd_count != e.fc || stall_count != e.sc) begin
          bad++;
          $display("FAIL cycle@%0t: got sel1=%0d sel2=%0d stall=%0b fc=%0d sc=%0d, want %0d %0d %0b %0d %0d",
                   $time, fwd_sel1, fwd_sel2, load_use_stall, fwd_count, stall_count,
                   e.s1, e.s2, e.st, e.fc, e.sc);
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [9];
    logic [31:0] nop;
    nop = enc_i(ARI, 5'd0, 5'd0, 12'd0);
    ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, ARI, R};

    step(nop, 1'b0, 1'b0, 1'b1);
    step(nop, 1'b1, 1'b0, 1'b1);
    expect_now("reset_idle", 0, 0, 1'b0);
    expect_cnt("reset_cnt", 32'd0, 32'd0);

    step(enc_i(ARI, 5'd3, 5'd0, 12'd1), 1'b1, 1'b0, 1'b0);
    step(enc_i(ARI, 5'd3, 5'd0, 12'd2), 1'b1, 1'b0, 1'b0);
    step(enc_r(R, 5'd4, 5'd3, 5'd3), 1'b0, 1'b0, 1'b0);
    expect_now("youngest_wins", 1, 1, 1'b0);
    step(enc_r(R, 5'd4, 5'd3, 5'd3), 1'b0, 1'b0, 1'b0);
    expect_now("aged_to_stage2", 2, 2, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);

    step(enc_i(LD, 5'd6, 5'd1, 12'd0), 1'b1, 1'b0, 1'b0);
    step(enc_r(R, 5'd7, 5'd6, 5'd2), 1'b1, 1'b0, 1'b0);
    expect_now("load_use_stall", 1, 0, 1'b1);
    step(enc_r(R, 5'd7, 5'd6, 5'd2), 1'b1, 1'b0, 1'b0);
    expect_now("load_use_resolved", 2, 0, 1'b0);
    step(nop, 1'b0, 1'b0, 1'b0);
    expect_cnt("load_use_counters", 32'd1, 32'd1);
    step(nop, 1'b0, 1'b0, 1'b0);

    step(enc_r(ST, 5'd0, 5'd1, 5'd1), 1'b1, 1'b0, 1'b0);
    step(enc_i(ARI, 5'd1, 5'd1, 12'd1), 1'b0, 1'b0, 1'b0);
    expect_now("store_no_rd", 0, 0, 1'b0);
    step(enc_i(ARI, 5'd5, 5'd0, 12'd7), 1'b1, 1'b0, 1'b0);
    step({20'h00528, 5'd5, LUI}, 1'b0, 1'b0, 1'b0);
    expect_now("lui_no_rs", 0, 0, 1'b0);
    step(nop, 1'b1, 1'b0, 1'b0);
    step(enc_r(R, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0);
    expect_now("x0_never_fwd", 0, 0, 1'b0);

    step(enc_i(ARI, 5'd8, 5'd0, 12'd1), 1'b1, 1'b0, 1'b0);
    step(enc_i(ARI, 5'd8, 5'd0, 12'd2), 1'b1, 1'b0, 1'b0);
    step(enc_i(ARI, 5'd8, 5'd0, 12'd3), 1'b1, 1'b1, 1'b0);
    step(enc_r(R, 5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 1'b0);
    expect_now("flush_clears", 0, 0, 1'b0);

    step(enc_i(ARI, 5'd1, 5'd0, 12'd1), 1'b1, 1'b0, 1'b0);
    step(enc_i(ARI, 5'd2, 5'd0, 12'd2), 1'b1, 1'b0, 1'b0);
    step(enc_r(R, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    expect_now("pre_reset_fwd", 2, 1, 1'b0);
    step(enc_r(R, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b1);
    expect_now("in_reset", 0, 0, 1'b0);
    step(enc_r(R, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    expect_now("after_reset", 0, 0, 1'b0);
    expect_cnt("after_reset_cnt", 32'd0, 32'd0);

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] inst;
      inst = enc_r(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step(inst, $urandom_range(0, 9) < 8, $urandom_range(0, 24) == 0, $urandom_range(0, 299) == 0);
    end
    step(nop, 1'b0, 1'b0, 1'b0);

    drv_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the single-stage Data1Sel forwarding select.
- Tracks destination registers of the last DEPTH issued instructions in a shift-register scoreboard.
- Produces per-operand forwarding selects for both rs1 and rs2, plus a load-use stall.
- Sits between decode (stage 2) and the execute-stage operand muxes; the stall feeds PC/IF-ID hold logic.

Parameters:
- DEPTH, 2, number of in-flight stages tracked after decode (1 = EX, 2 = MEM/WB, ...); legal range 1..7.
- LOAD_STALL, 1, number of youngest stages in which a matching load forces a stall; must be <= DEPTH.
- SELW, $clog2(DEPTH+1), localparam-style width of the select outputs; not to be overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- dec_inst  in  32  instruction currently in decode
- issue_valid  in  1  decode instruction advances into stage 1 at this edge
- flush  in  1  kill all in-flight entries (branch/jump redirect)
- fwd_sel1  out  SELW  rs1 source: 0 = regfile, k = result of stage k
- fwd_sel2  out  SELW  rs2 source, same encoding
- load_use_stall  out  1  hold decode, insert bubble
- fwd_count  out  32  forwarding-event counter (optional feature)
- stall_count  out  32  stall-cycle counter (optional feature)

Behaviour:
- Entry fields: valid, rd[4:0], is_load. Registers entry[1..DEPTH]; entry 1 is the youngest instruction.
- Decode classification uses the `Opcode.vh` macros:
  - has_rd = opcode is not OPC_BRANCH or OPC_STORE, and rd != 0.
  - has_rs1 = opcode is not OPC_LUI, OPC_AUIPC or OPC_JAL.
  - has_rs2 = opcode is R-type, OPC_STORE or OPC_BRANCH.
  - is_load = opcode is OPC_LOAD.
- Select for operand n:
  - Candidate stages are those with entry[k].valid, has_rsn, and rs field == entry[k].rd.
  - The smallest matching k wins (youngest result).
  - With no match, the select is 0.
  - rs == x0 always yields 0.
- load_use_stall = 1 when any candidate match (rs1 or rs2) hits an entry with k <= LOAD_STALL and is_load = 1.
  - Selects are still driven while stalled.
  - The next-cycle decision is evaluated against the shifted state.
- Outputs are combinational from registered state and dec_inst, with zero added latency.
- Every posedge: entry[k+1] <= entry[k] for k = 1..DEPTH-1, and entry[DEPTH] drops off.
  - entry[1] is loaded with the decode entry if issue_valid && !load_use_stall.
  - Otherwise entry[1] becomes a bubble (valid = 0).
- flush (synchronous) has priority over issue:
  - All entries go to valid = 0 at the edge.
  - Nothing from decode is captured that cycle.
- Async rst clears every entry's valid, rd and is_load, and both counters. While reset is asserted and after release: fwd_sel1 = fwd_sel2 = 0, load_use_stall = 0.
- Reset mid-pipeline discards all in-flight tracking; no stale forwarding after release.
- Boundary cases:
  - DEPTH = 1: SELW = 1.
  - An instruction writing the same rd as its own rs does not self-forward; only older entries are compared.
  - Two in-flight entries with the same rd resolve to the younger one.

Optional Feature:
- Macro FWD_SCOREBOARD_STATS_EN.
- Defined:
  - fwd_count increments by 1 per cycle in which fwd_sel1 != 0 or fwd_sel2 != 0, and issue_valid && !load_use_stall.
  - stall_count increments by 1 per cycle with load_use_stall = 1.
  - Both counters wrap at 2^32 and clear on rst.
- Not defined: both ports are tied to 32'd0 and no counter flops exist.

Test Plan:
- Reset then idle: rst pulse mid-run with entries valid -> after release all selects 0 and stall 0; `add x5,x1,x2` in decode -> fwd_sel1 = 0.
- Youngest-wins: issue `addi x3,x0,1`, then `addi x3,x0,2`, then decode `add x4,x3,x3` (DEPTH = 2) -> fwd_sel1 = 1, fwd_sel2 = 1. One cycle later with a bubble issued -> both = 2.
- Load-use: issue `lw x6,0(x1)`, decode `add x7,x6,x2` -> load_use_stall = 1 for one cycle, a bubble enters entry 1; next cycle stall = 0 and fwd_sel1 = 2.
- Operand classification:
  - Store `sw x1,0(x1)` in entry 1, decode `addi x1,x1,1` -> fwd_sel1 = 0 (stores have no rd).
  - `addi x5,...` in entry 1, decode `lui x5,1` -> both selects 0.
  - `addi x0,x0,0` in entry 1, decode using x0 -> both selects 0.
- Flush: entries hold x8 writers, assert flush with issue_valid = 1 -> next cycle decode `add x9,x8,x8` gives fwd_sel1 = fwd_sel2 = 0.
- With FWD_SCOREBOARD_STATS_EN: run the load-use scenario -> stall_count = 1, fwd_count = 1. Without the macro -> both read 0.
